// File: rtl/rx_core_param.sv
// rx_core_param: oversampling UART receive core with majority-vote bit
// decisions, runtime frame format and a show-ahead character FIFO.
//
// Ports:
//   clk, rst            system clock, asynchronous active-low reset
//   AcqSig_i            one-clk acquisition tick, OVERSAMPLE per bit
//   Rx_i                asynchronous serial line, idle high
//   cfg_bits_i          data bits = 5 + cfg_bits_i (clipped to DATA_MAX)
//   cfg_parity_i        00 none, 01 even, 10 odd, 11 mark
//   cfg_stop2_i         two stop bits
//   cfg_msb_first_i     MSB transmitted first
//   rd_i                pop FIFO head
//   data_o, err_o       FIFO head data and {break, framing, parity}
//   empty_o, full_o     FIFO status
//   level_o             FIFO occupancy
//   overrun_o           sticky dropped-character flag
//   clr_overrun_i       clear overrun_o
//   busy_o              receiver not idle
module rx_core_param #(
    parameter int DATA_MAX   = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                AcqSig_i,
    input  logic                Rx_i,
    input  logic [1:0]          cfg_bits_i,
    input  logic [1:0]          cfg_parity_i,
    input  logic                cfg_stop2_i,
    input  logic                cfg_msb_first_i,
    input  logic                rd_i,
    output logic [DATA_MAX-1:0] data_o,
    output logic [2:0]          err_o,
    output logic                empty_o,
    output logic                full_o,
    output logic [FIFO_AW:0]    level_o,
    output logic                overrun_o,
    input  logic                clr_overrun_i,
    output logic                busy_o
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int M  = OVERSAMPLE / 2;
    localparam int EW = DATA_MAX + 3;

    localparam logic [CW-1:0] C_LO  = CW'(M - 1);
    localparam logic [CW-1:0] C_MID = CW'(M);
    localparam logic [CW-1:0] C_HI  = CW'(M + 1);
    localparam logic [CW-1:0] C_TOP = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT
    } state_t;

    state_t state, state_n;

    // Synchroniser plus one history flop for falling-edge detection.
    logic rx_m, rx_s, rx_d;
    logic fall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= Rx_i;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign fall = rx_d & ~rx_s;

    // Oversample counter and the two early vote samples.
    logic [CW-1:0] cnt;
    logic          samp_lo, samp_mid;
    logic          vote, vote_tick, wrap;

    assign vote_tick = AcqSig_i && (cnt == C_HI);
    assign wrap      = AcqSig_i && (cnt == C_TOP);
    assign vote      = (samp_lo & samp_mid) | (samp_lo & rx_s) | (samp_mid & rx_s);

    // Frame control strobes (FSM outputs).
    logic start_go, shift_en, par_en, stop1_v, wr_now, fr_now, brk_now;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            samp_lo  <= 1'b1;
            samp_mid <= 1'b1;
        end else begin
            if (start_go)
                cnt <= '0;
            else if (AcqSig_i)
                cnt <= wrap ? '0 : cnt + CW'(1);
            if (AcqSig_i && cnt == C_LO)
                samp_lo <= rx_s;
            if (AcqSig_i && cnt == C_MID)
                samp_mid <= rx_s;
        end
    end

    // Frame format, captured at the start edge.
    logic [3:0] n_cfg;
    logic [3:0] c_n;
    logic [1:0] c_par;
    logic       c_stop2, c_msb;

    always_comb begin
        n_cfg = 4'd5 + {2'b00, cfg_bits_i};
        if (int'(n_cfg) > DATA_MAX)
            n_cfg = 4'(DATA_MAX);
    end

    // Frame datapath.
    logic [DATA_MAX-1:0] sh, sh_next;
    logic [3:0]          bitcnt;
    logic                par_bit, perr, fr1, par_exp;
    logic                wr_req;
    logic [EW-1:0]       wr_ent;

    always_comb begin
        sh_next = '0;
        if (c_msb) begin
            sh_next = {sh[DATA_MAX-2:0], vote};
        end else begin
            sh_next = sh >> 1;
            for (int i = 0; i < DATA_MAX; i++)
                if (i == int'(c_n) - 1)
                    sh_next[i] = vote;
        end
    end

    always_comb begin
        unique case (c_par)
            2'b01:   par_exp = ^sh;
            2'b10:   par_exp = ~^sh;
            default: par_exp = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:
                if (fall)
                    state_n = START;
            START:
                if (vote_tick && vote)
                    state_n = IDLE;
                else if (wrap)
                    state_n = DATA;
            DATA:
                if (wrap && bitcnt == c_n)
                    state_n = (c_par != 2'b00) ? PARITY : STOP1;
            PARITY:
                if (wrap)
                    state_n = STOP1;
            STOP1:
                if (wr_now)
                    state_n = brk_now ? BRK_WAIT : IDLE;
                else if (wrap && c_stop2)
                    state_n = STOP2;
            STOP2:
                if (wr_now)
                    state_n = brk_now ? BRK_WAIT : IDLE;
            BRK_WAIT:
                if (rx_s)
                    state_n = IDLE;
            default:
                state_n = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        start_go = 1'b0;
        shift_en = 1'b0;
        par_en   = 1'b0;
        stop1_v  = 1'b0;
        wr_now   = 1'b0;
        fr_now   = 1'b0;
        brk_now  = 1'b0;
        busy_o   = (state != IDLE);
        unique case (state)
            IDLE:   start_go = fall;
            DATA:   shift_en = vote_tick;
            PARITY: par_en   = vote_tick;
            STOP1: begin
                stop1_v = vote_tick;
                wr_now  = vote_tick && !c_stop2;
                fr_now  = ~vote;
            end
            STOP2: begin
                wr_now = vote_tick;
                fr_now = fr1 | ~vote;
            end
            default: ;
        endcase
        // Break: all-zero character, zero parity bit and a low stop.
        brk_now = wr_now && (sh == '0) && fr_now &&
                  ((c_par == 2'b00) || !par_bit);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_n     <= '0;
            c_par   <= '0;
            c_stop2 <= 1'b0;
            c_msb   <= 1'b0;
            sh      <= '0;
            bitcnt  <= '0;
            par_bit <= 1'b0;
            perr    <= 1'b0;
            fr1     <= 1'b0;
            wr_req  <= 1'b0;
            wr_ent  <= '0;
        end else begin
            if (start_go) begin
                c_n     <= n_cfg;
                c_par   <= cfg_parity_i;
                c_stop2 <= cfg_stop2_i;
                c_msb   <= cfg_msb_first_i;
                sh      <= '0;
                bitcnt  <= '0;
                par_bit <= 1'b0;
                perr    <= 1'b0;
                fr1     <= 1'b0;
            end
            if (shift_en) begin
                sh     <= sh_next;
                bitcnt <= bitcnt + 4'd1;
            end
            if (par_en) begin
                par_bit <= vote;
                perr    <= (vote != par_exp);
            end
            if (stop1_v)
                fr1 <= ~vote;
            // Write request is registered; the FIFO commits one clk later.
            wr_req <= wr_now;
            if (wr_now)
                wr_ent <= {brk_now, fr_now, perr & ~brk_now, sh};
        end
    end

    // Show-ahead FIFO.
    logic [EW-1:0]      mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wptr, rptr;
    logic [FIFO_AW:0]   level;
    logic               do_rd, do_wr;
    logic [EW-1:0]      head;

    assign empty_o = (level == '0);
    assign full_o  = (level == (FIFO_AW+1)'(FIFO_DEPTH));
    assign level_o = level;
    assign do_rd   = rd_i && !empty_o;
    assign do_wr   = wr_req && (!full_o || do_rd);
    assign head    = mem[rptr];
    assign data_o  = empty_o ? '0 : head[DATA_MAX-1:0];
    assign err_o   = empty_o ? 3'b000 : head[EW-1:DATA_MAX];

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wptr] <= wr_ent;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            overrun_o <= 1'b0;
        end else begin
            if (do_wr)
                wptr <= wptr + FIFO_AW'(1);
            if (do_rd)
                rptr <= rptr + FIFO_AW'(1);
            unique case ({do_wr, do_rd})
                2'b10:   level <= level + (FIFO_AW+1)'(1);
                2'b01:   level <= level - (FIFO_AW+1)'(1);
                default: level <= level;
            endcase
            if (wr_req && !do_wr)
                overrun_o <= 1'b1;
            else if (clr_overrun_i)
                overrun_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_core_param.sv
// tb_rx_core_param: directed frame bench for rx_core_param.
// Serial frames are bit-banged at 16 ticks per bit, one tick per 4 clk.
module tb_rx_core_param;

    localparam int DM = 8;
    localparam int OS = 16;
    localparam int FD = 4;
    localparam int FA = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          acq = 1'b0;
    logic          rx = 1'b1;
    logic [1:0]    cfg_bits = 2'd3;
    logic [1:0]    cfg_parity = 2'd0;
    logic          cfg_stop2 = 1'b0;
    logic          cfg_msb = 1'b0;
    logic          rd = 1'b0;
    logic          clr = 1'b0;
    logic [DM-1:0] data;
    logic [2:0]    err;
    logic          empty, full, overrun, busy;
    logic [FA:0]   level;

    int n_chk = 0;
    int n_pass = 0;

    rx_core_param #(
        .DATA_MAX(DM), .OVERSAMPLE(OS), .FIFO_DEPTH(FD), .FIFO_AW(FA)
    ) dut (
        .clk(clk), .rst(rst), .AcqSig_i(acq), .Rx_i(rx),
        .cfg_bits_i(cfg_bits), .cfg_parity_i(cfg_parity),
        .cfg_stop2_i(cfg_stop2), .cfg_msb_first_i(cfg_msb),
        .rd_i(rd), .data_o(data), .err_o(err), .empty_o(empty),
        .full_o(full), .level_o(level), .overrun_o(overrun),
        .clr_overrun_i(clr), .busy_o(busy)
    );

    always #5 clk = ~clk;

    logic [1:0] tdiv = 2'd0;
    always @(negedge clk) begin
        tdiv = tdiv + 2'd1;
        acq  = (tdiv == 2'd0);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic hold_bit();
        repeat (64) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input int n,
                        input logic [1:0] par, input logic s2,
                        input logic msb, input logic bad);
        logic [7:0] m;
        logic       p;
        cfg_bits   = 2'(n - 5);
        cfg_parity = par;
        cfg_stop2  = s2;
        cfg_msb    = msb;
        m = d & 8'((1 << n) - 1);
        rx = 1'b0;
        hold_bit();
        for (int i = 0; i < n; i++) begin
            rx = msb ? m[n-1-i] : m[i];
            hold_bit();
        end
        if (par != 2'b00) begin
            p  = (par == 2'b01) ? ^m : (par == 2'b10) ? ~^m : 1'b1;
            rx = p ^ bad;
            hold_bit();
        end
        rx = 1'b1;
        hold_bit();
        if (s2)
            hold_bit();
        hold_bit();
    endtask

    task automatic pop();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] m77;
        m77 = 8'h77;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_level", level, 0);
        check("rst_ovr", overrun, 0);
        check("rst_busy", busy, 0);
        check("rst_data", data, 0);
        check("rst_err", err, 0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // 8N1 LSB-first 0xA5
        send(8'hA5, 8, 2'b00, 1'b0, 1'b0, 1'b0);
        check("a5_level", level, 1);
        check("a5_data", data, 8'hA5);
        check("a5_err", err, 0);
        check("a5_empty", empty, 0);
        pop();
        check("a5_pop_empty", empty, 1);
        check("a5_pop_data", data, 0);

        // 7E2 MSB-first, bad parity then good
        send(8'h5A, 7, 2'b01, 1'b1, 1'b1, 1'b1);
        send(8'h12, 7, 2'b01, 1'b1, 1'b1, 1'b0);
        check("7e2_level", level, 2);
        check("7e2_bad_data", data, 8'h5A);
        check("7e2_bad_err", err, 3'b001);
        pop();
        check("7e2_ok_data", data, 8'h12);
        check("7e2_ok_err", err, 3'b000);
        pop();
        check("7e2_empty", empty, 1);

        // False start
        cfg_bits   = 2'd3;
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;
        cfg_msb    = 1'b0;
        rx = 1'b0;
        repeat (8) @(negedge clk);
        check("fs_busy", busy, 1);
        repeat (8) @(negedge clk);
        rx = 1'b1;
        hold_bit();
        check("fs_idle", busy, 0);
        check("fs_level", level, 0);

        // Break: line low for 20 bit times
        rx = 1'b0;
        repeat (20) hold_bit();
        check("brk_level", level, 1);
        check("brk_busy", busy, 1);
        check("brk_data", data, 0);
        check("brk_err", err, 3'b110);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        check("brk_release", busy, 0);
        pop();
        send(8'h33, 8, 2'b00, 1'b0, 1'b0, 1'b0);
        check("post_brk_level", level, 1);
        check("post_brk_data", data, 8'h33);
        check("post_brk_err", err, 0);
        pop();

        // Overflow with FIFO_DEPTH=4
        for (int i = 1; i <= 5; i++)
            send(8'(i), 8, 2'b00, 1'b0, 1'b0, 1'b0);
        check("ovf_full", full, 1);
        check("ovf_level", level, 4);
        check("ovf_flag", overrun, 1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovf_head%0d", i), data, i);
            pop();
        end
        check("ovf_empty", empty, 1);
        check("ovf_sticky", overrun, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check("ovf_clr", overrun, 0);

        // Reset mid-frame with two entries queued
        send(8'h44, 8, 2'b00, 1'b0, 1'b0, 1'b0);
        send(8'h55, 8, 2'b00, 1'b0, 1'b0, 1'b0);
        check("mid_level", level, 2);
        rx = 1'b0;
        hold_bit();
        for (int i = 0; i < 3; i++) begin
            rx = m77[i];
            hold_bit();
        end
        check("mid_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_level", level, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", data, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_full", full, 0);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        hold_bit();
        send(8'h3C, 8, 2'b00, 1'b0, 1'b0, 1'b0);
        check("post_rst_level", level, 1);
        check("post_rst_data", data, 8'h3C);
        check("post_rst_err", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
